// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-stage definitions: next-PC select encodings, fetch FSM states
// and the default reset vector.
package ifetch_unit_pkg;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_JR     = 2'b11;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_ISSUE = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Combinational next-PC selection (PLUS4 / BRANCH / JUMP, plus JR when
// IFETCH_JR_EN is defined).
module npc_calc
   import ifetch_unit_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] PC,
   input  logic [31:0]   Instr,
   input  logic [1:0]    NPCOp,
   input  logic [31:0]   RD1,
   output logic [AW-1:0] NPC,
   output logic [AW-1:0] PCPlus4
);

   logic [AW-1:0] branch_target;
   logic [AW-1:0] jump_target;
   logic          unused_bits;

   assign PCPlus4 = PC + AW'(4);

   // Branch offset is a signed word count; the sum wraps silently.
   assign branch_target = PCPlus4 + {{(AW-18){Instr[15]}}, Instr[15:0], 2'b00};
   assign jump_target   = {PCPlus4[AW-1:28], Instr[25:0], 2'b00};

   always_comb begin
      NPC = PCPlus4;
      case (NPCOp)
         NPC_BRANCH: NPC = branch_target;
         NPC_JUMP:   NPC = jump_target;
`ifdef IFETCH_JR_EN
         NPC_JR:     NPC = {RD1[AW-1:2], 2'b00};
`endif
         default:    NPC = PCPlus4;
      endcase
   end

`ifdef IFETCH_JR_EN
   assign unused_bits = ^{Instr[31:26], RD1[1:0]};
`else
   assign unused_bits = ^{Instr[31:26], RD1};
`endif

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns PC, runs the req/gnt/rvalid handshake and holds
// Instr until retirement. JR support is enabled by defining IFETCH_JR_EN.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int            AW       = 32,
   parameter logic [AW-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [31:0]   imem_rdata,
   output logic [31:0]   Instr,
   output logic          instr_valid,
   output logic [AW-1:0] PC,
   output logic [AW-1:0] PCPlus4,
   input  logic [1:0]    NPCOp,
   input  logic [31:0]   RD1,
   input  logic          retire
);

   fetch_state_e  state;
   logic [AW-1:0] npc;

   npc_calc #(.AW(AW)) u_npc_calc (
      .PC      (PC),
      .Instr   (Instr),
      .NPCOp   (NPCOp),
      .RD1     (RD1),
      .NPC     (npc),
      .PCPlus4 (PCPlus4)
   );

   assign imem_addr = PC;

   // imem_req is registered so it is high exactly while the FSM sits in FETCH;
   // inputs not relevant to the current state are simply not looked at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         PC          <= {RESET_PC[AW-1:2], 2'b00};
         Instr       <= '0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
            end
            S_FETCH: begin
               if (imem_gnt) begin
                  imem_req <= 1'b0;
                  if (imem_rvalid) begin
                     Instr       <= imem_rdata;
                     instr_valid <= 1'b1;
                     state       <= S_ISSUE;
                  end else begin
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  Instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (retire) begin
                  PC          <= {npc[AW-1:2], 2'b00};
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= S_FETCH;
               end
            end
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: expected fetch addresses are queued by a
// next-PC model on each retire and popped when the DUT issues a request.
module tb_ifetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] Instr;
   logic        instr_valid;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic [1:0]  NPCOp;
   logic [31:0] RD1;
   logic        retire;

   int          tests;
   int          failed;
   logic [31:0] sb[$];
   logic [31:0] last_instr;

   ifetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .Instr       (Instr),
      .instr_valid (instr_valid),
      .PC          (PC),
      .PCPlus4     (PCPlus4),
      .NPCOp       (NPCOp),
      .RD1         (RD1),
      .retire      (retire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] ins,
                                              input logic [1:0] op, input logic [31:0] rd1);
      logic [31:0] p4;
      logic [31:0] off;
      p4  = pc + 32'd4;
      off = {{16{ins[15]}}, ins[15:0]} << 2;
      case (op)
         2'b01:   return p4 + off;
         2'b10:   return {p4[31:28], ins[25:0], 2'b00};
`ifdef IFETCH_JR_EN
         2'b11:   return rd1 & 32'hFFFF_FFFC;
`else
         2'b11:   return p4 | (rd1 & 32'h0);
`endif
         default: return p4;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_expected(output logic [31:0] exp_addr);
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
      exp_addr = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
      checkOutput("fetch_addr", imem_addr, exp_addr);
   endtask

   // One complete fetch/issue/retire transaction with optional gnt and rvalid
   // stalls; retire noise is driven in the states that must ignore it.
   task automatic applyStimulus(input logic [31:0] word, input int gnt_wait, input int rv_wait,
                                input logic [1:0] op, input logic [31:0] rd1, input logic noise);
      logic [31:0] exp_addr;
      pop_expected(exp_addr);
      for (int i = 0; i < gnt_wait; i++) begin
         imem_gnt = 1'b0;
         retire   = noise;
         @(negedge clk);
         checkOutput("addr_hold", imem_addr, exp_addr);
         checkOutput("req_hold", {31'd0, imem_req}, 32'd1);
      end
      retire      = 1'b0;
      imem_gnt    = 1'b1;
      imem_rvalid = (rv_wait == 0);
      imem_rdata  = (rv_wait == 0) ? word : 32'hDEAD_BEEF;
      @(negedge clk);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (rv_wait > 0) begin
         for (int i = 1; i < rv_wait; i++) begin
            checkOutput("wait_req", {31'd0, imem_req}, 32'd0);
            checkOutput("wait_valid", {31'd0, instr_valid}, 32'd0);
            checkOutput("wait_instr", Instr, last_instr);
            retire     = noise;
            imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
         end
         retire      = 1'b0;
         imem_rvalid = 1'b1;
         imem_rdata  = word;
         @(negedge clk);
         imem_rvalid = 1'b0;
      end
      checkOutput("issue_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("issue_instr", Instr, word);
      checkOutput("issue_pc", PC, exp_addr);
      checkOutput("issue_pc4", PCPlus4, exp_addr + 32'd4);
      last_instr = word;
      sb.push_back(model_npc(exp_addr, word, op, rd1));
      NPCOp  = op;
      RD1    = rd1;
      retire = 1'b1;
      @(negedge clk);
      retire = 1'b0;
      NPCOp  = 2'($urandom);
      RD1    = $urandom;
      checkOutput("retired_valid", {31'd0, instr_valid}, 32'd0);
   endtask

   localparam logic [31:0] ADDI = 32'h2010_0005;

   initial begin
      logic [31:0] exp_addr;
      tests       = 0;
      failed      = 0;
      last_instr  = 32'd0;
      rst         = 1'b1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      NPCOp       = 2'b00;
      RD1         = 32'd0;
      retire      = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_pc", PC, 32'h0000_3000);
      checkOutput("rst_instr", Instr, 32'd0);
      checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
      rst = 1'b0;
      sb.push_back(32'h0000_3000);

      // Back-to-back sequential fetches
      applyStimulus(ADDI, 0, 0, 2'b00, 32'd0, 1'b0);
      applyStimulus(ADDI, 0, 0, 2'b00, 32'd0, 1'b0);
      applyStimulus(ADDI, 0, 0, 2'b00, 32'd0, 1'b0);
      applyStimulus(ADDI, 0, 0, 2'b00, 32'd0, 1'b0);

      // Branches backward and forward from 0x3010
      applyStimulus({6'h04, 10'h000, 16'hFFFE}, 0, 0, 2'b01, 32'd0, 1'b0);
      applyStimulus(ADDI, 0, 0, 2'b00, 32'd0, 1'b0);
      applyStimulus({6'h04, 10'h000, 16'h0003}, 0, 0, 2'b01, 32'd0, 1'b0);

      // Stalled grant and delayed rvalid with retire noise, then JR select
      applyStimulus(32'h0123_4567, 3, 4, 2'b11, 32'h0000_3103, 1'b1);
      applyStimulus({6'h02, 26'h000_0C10}, 0, 0, 2'b10, 32'd0, 1'b0);

      // Asynchronous reset while waiting on rvalid at 0x3040
      pop_expected(exp_addr);
      checkOutput("pre_rst_addr", exp_addr, 32'h0000_3040);
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      checkOutput("rst_wait_req", {31'd0, imem_req}, 32'd0);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_pc", PC, 32'h0000_3000);
      checkOutput("async_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("async_instr", Instr, 32'd0);
      @(negedge clk);
      rst         = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0001;
      @(negedge clk);
      imem_rvalid = 1'b0;
      checkOutput("late_rvalid_instr", Instr, 32'd0);
      checkOutput("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);
      last_instr = 32'd0;
      sb.delete();
      sb.push_back(32'h0000_3000);

      // Jump to 0, branch wraps below zero, then jumps in the top segment
      applyStimulus({6'h02, 26'h000_0000}, 0, 0, 2'b10, 32'd0, 1'b0);
      applyStimulus({6'h04, 10'h000, 16'hFFF0}, 0, 0, 2'b01, 32'd0, 1'b0);
      applyStimulus({6'h02, 26'h000_0000}, 0, 0, 2'b10, 32'd0, 1'b0);
      applyStimulus({6'h02, 26'h000_0C00}, 1, 2, 2'b10, 32'd0, 1'b1);
      applyStimulus(ADDI, 0, 0, 2'b00, 32'd0, 1'b0);
      pop_expected(exp_addr);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder; supplies Instr (Op = Instr[31:26], Funct = Instr[5:0]) to it.
- Consumes the decoder's NPCOp to compute and register the next PC.
- Owns the PC register and a req/gnt/rvalid handshake to instruction memory.
- Holds each fetched instruction stable until the datapath signals retirement.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; must be word aligned.
- AW, 32, PC / memory address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  AW  fetch address; always equals PC.
- imem_gnt  input  1  memory accepted request.
- imem_rvalid  input  1  imem_rdata valid.
- imem_rdata  input  32  fetched instruction word.
- Instr  output  32  held instruction to decoder/datapath.
- instr_valid  output  1  Instr valid and awaiting retirement.
- PC  output  AW  address of Instr.
- PCPlus4  output  AW  PC+4; feeds the WDSel_FromPC path for jal.
- NPCOp  input  2  next-PC select from decoder: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR (JR only with the optional feature).
- RD1  input  32  rs register value, used only for JR.
- retire  input  1  datapath completed Instr this cycle; commit NPC.

Behaviour:
- Reset (async, any state, including mid-transaction):
  - PC=RESET_PC, Instr=0, instr_valid=0, imem_req=0, state=IDLE.
  - Any outstanding memory transaction is abandoned; the memory is reset on the same rst.
- FSM states: IDLE, FETCH, WAIT, ISSUE.
- IDLE: unconditionally goes to FETCH on the next edge.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - req and addr held stable while gnt=0.
  - gnt=1 & rvalid=0 -> WAIT.
  - gnt=1 & rvalid=1 (same cycle) -> capture Instr, go to ISSUE.
- WAIT:
  - imem_req=0.
  - rvalid=1 -> Instr<=imem_rdata, instr_valid<=1, go to ISSUE.
  - Stays in WAIT indefinitely otherwise.
- ISSUE:
  - instr_valid=1; Instr and PC held.
  - retire=1 -> PC<=NPC, instr_valid<=0, go to FETCH.
  - Minimum fetch-to-issue latency: 1 cycle (FETCH with gnt & rvalid).
- Ignored inputs (no effect):
  - retire outside ISSUE.
  - rvalid outside WAIT, or outside FETCH-with-gnt.
  - gnt outside FETCH.
- NPC computation (combinational from PC, Instr, NPCOp, RD1); all additions modulo 2^AW, wrap silently:
  - PLUS4: PC+4.
  - BRANCH: PC+4 + (sign_extend(Instr[15:0]) << 2).
  - JUMP: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - 11 without the feature: treated as PLUS4.
- PC[1:0] is always 00. Every written PC has bits [1:0] forced to 0.
- NPCOp is sampled only on the retire edge; it may change freely in other cycles.
- PCPlus4 is combinational from the PC register.

Optional Feature:
- Macro: IFETCH_JR_EN.
- Defined: NPCOp=2'b11 selects NPC = {RD1[31:2], 2'b00} (jr support).
- Undefined: NPCOp=2'b11 behaves as PLUS4; RD1 is unused, port retained for a stable interface.

Decomposition:
- Shared package (alongside the control-encoding definitions):
  - NPC_PLUS4 / NPC_BRANCH / NPC_JUMP / NPC_JR 2-bit constants.
  - Fetch FSM state typedef (IDLE, FETCH, WAIT, ISSUE).
  - RESET_PC default.
- One sub-module: npc_calc, purely combinational (PC, Instr, NPCOp, RD1 -> NPC, PCPlus4).
  - It is guarded internally by IFETCH_JR_EN.
- The FSM and PC/Instr registers live in ifetch_unit.

Test Plan:
- Reset, then gnt=1 & rvalid=1 every cycle, imem_rdata=32'h2010_0005, retire on each ISSUE, NPCOp=00 -> fetch addresses 0x3000, 0x3004, 0x3008; instr_valid high one cycle per instruction.
- At PC=0x3010, Instr imm16=16'hFFFE, NPCOp=01, retire -> next imem_addr=0x300C; imm16=16'h0003 -> next imem_addr=0x3020.
- At PC=0xF000_0000, Instr[25:0]=26'h000_0C00, NPCOp=10, retire -> next imem_addr=0xF000_3000.
- gnt held 0 for 3 cycles, then gnt=1; rvalid 4 cycles later -> imem_addr stable throughout; Instr captured only on rvalid; retire pulses during WAIT ignored.
- rst asserted in WAIT with PC=0x3040 -> PC=0x3000 and instr_valid=0 immediately (asynchronous); a late rvalid after release is not captured.
- With IFETCH_JR_EN, RD1=0x0000_3103, NPCOp=11, retire -> next imem_addr=0x3100; without the macro -> PC+4.
